// File: rtl/ysyx_22040632_memreq_arb.sv
// ---------------------------------------------------------------------------
// ysyx_22040632_memreq_arb
//
// Round-robin arbiter that merges NCH cache/uncached requesters onto a single
// downstream memory port. The winning request is latched in full. It is then
// presented on mem_* until the memory answers or the optional timeout expires.
// Finally a one-cycle completion pulse goes back to the winner on req_ready.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid[NCH]    per-channel request valid (held until req_ready)
//   req_write[NCH]    1 = write, 0 = read
//   req_addr          channel i at [i*AW +: AW]
//   req_size          log2 bytes, channel i at [i*3 +: 3]
//   req_wdata         channel i at [i*DW +: DW]
//   req_wmask         channel i at [i*MW +: MW]
//   req_ready[NCH]    one-hot completion pulse to the granted channel
//   req_rdata         read data, broadcast, meaningful with a req_ready bit
//   req_err           high together with req_ready on a timed-out transaction
//   mem_valid         downstream request valid (high for the whole BUSY phase)
//   mem_write/addr/size/wdata/wmask   latched copy of the granted request
//   mem_ready         downstream completion pulse
//   mem_rdata         downstream read data, valid with mem_ready
//   gnt_id            index of the channel owning the port
// ---------------------------------------------------------------------------
module ysyx_22040632_memreq_arb #(
  parameter int NCH     = 2,
  parameter int AW      = 32,
  parameter int DW      = 64,
  parameter int TIMEOUT = 0,
  localparam int MW     = DW / 8,
  localparam int IW     = $clog2(NCH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NCH-1:0]      req_valid,
  input  logic [NCH-1:0]      req_write,
  input  logic [NCH*AW-1:0]   req_addr,
  input  logic [NCH*3-1:0]    req_size,
  input  logic [NCH*DW-1:0]   req_wdata,
  input  logic [NCH*MW-1:0]   req_wmask,
  output logic [NCH-1:0]      req_ready,
  output logic [DW-1:0]       req_rdata,
  output logic                req_err,
  output logic                mem_valid,
  output logic                mem_write,
  output logic [AW-1:0]       mem_addr,
  output logic [2:0]          mem_size,
  output logic [DW-1:0]       mem_wdata,
  output logic [MW-1:0]       mem_wmask,
  input  logic                mem_ready,
  input  logic [DW-1:0]       mem_rdata,
  output logic [IW-1:0]       gnt_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Timeout counter only needs to reach TIMEOUT-1; keep at least one bit so
  // the disabled configuration still elaborates.
  localparam int            CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic          TO_EN   = (TIMEOUT > 0);
  localparam logic [IW:0]   NCH_W   = (IW + 1)'(NCH);

  state_t           state_reg, state_next;
  logic [IW-1:0]    rr_ptr_reg;
  logic [IW-1:0]    gnt_id_reg;
  logic [CW-1:0]    to_cnt_reg;
  logic             err_reg;
  logic [DW-1:0]    rdata_reg;
  logic             mem_write_reg;
  logic [AW-1:0]    mem_addr_reg;
  logic [2:0]       mem_size_reg;
  logic [DW-1:0]    mem_wdata_reg;
  logic [MW-1:0]    mem_wmask_reg;

  // Per-channel views of the flattened request buses.
  logic             ch_write [NCH];
  logic [AW-1:0]    ch_addr  [NCH];
  logic [2:0]       ch_size  [NCH];
  logic [DW-1:0]    ch_wdata [NCH];
  logic [MW-1:0]    ch_wmask [NCH];
  logic [NCH-1:0]   gnt_onehot;

  genvar gi, gb;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      assign ch_write[gi]   = req_write[gi];
      assign ch_addr[gi]    = req_addr[gi*AW +: AW];
      assign ch_size[gi]    = req_size[gi*3 +: 3];
      assign ch_wdata[gi]   = req_wdata[gi*DW +: DW];
      assign ch_wmask[gi]   = req_wmask[gi*MW +: MW];
      assign gnt_onehot[gi] = (gnt_id_reg == IW'(gi));
    end
  endgenerate

  // Round-robin pick: rotate the valid vector so rr_ptr sits at bit 0, find
  // the lowest set bit there, then add rr_ptr back (mod NCH).
  logic [2*NCH-1:0] valid_dbl;
  logic [2*NCH-1:0] valid_shift;
  logic [NCH-1:0]   rot_valid;
  logic [NCH-1:0]   rot_hit;
  logic [IW-1:0]    sel_off;
  logic [IW:0]      sel_sum;
  logic [IW:0]      sel_wrap;
  logic [IW-1:0]    sel_id;
  logic             any_valid;

  assign valid_dbl   = {req_valid, req_valid};
  assign valid_shift = valid_dbl >> rr_ptr_reg;
  assign rot_valid   = valid_shift[NCH-1:0];
  assign any_valid   = |req_valid;

  generate
    for (gi = 0; gi < NCH; gi++) begin : g_hit
      if (gi == 0) begin : g_first
        assign rot_hit[gi] = rot_valid[gi];
      end else begin : g_rest
        assign rot_hit[gi] = rot_valid[gi] & ~(|rot_valid[gi-1:0]);
      end
    end
    // One-hot to binary: bit gb of the offset is set when the hit lies at a
    // position whose index has bit gb set.
    for (gb = 0; gb < IW; gb++) begin : g_off
      logic [NCH-1:0] pos_mask;
      for (gi = 0; gi < NCH; gi++) begin : g_mask
        assign pos_mask[gi] = (((gi >> gb) & 1) != 0);
      end
      assign sel_off[gb] = |(rot_hit & pos_mask);
    end
  endgenerate

  assign sel_sum  = {1'b0, rr_ptr_reg} + {1'b0, sel_off};
  assign sel_wrap = sel_sum - NCH_W;
  assign sel_id   = (sel_sum >= NCH_W) ? sel_wrap[IW-1:0] : sel_sum[IW-1:0];

  // Pointer moves just past the channel that was served.
  logic [IW:0]   gnt_inc;
  logic [IW-1:0] rr_after;
  assign gnt_inc  = {1'b0, gnt_id_reg} + (IW + 1)'(1);
  assign rr_after = (gnt_inc == NCH_W) ? '0 : gnt_inc[IW-1:0];

  logic timeout_hit;
  assign timeout_hit = TO_EN && (to_cnt_reg == TO_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and the state-decoded outputs.
  always_comb begin
    state_next = state_reg;
    mem_valid  = 1'b0;
    req_ready  = '0;
    req_err    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_valid) state_next = BUSY;
      end
      BUSY: begin
        mem_valid = 1'b1;
        if (mem_ready || timeout_hit) state_next = RESP;
      end
      RESP: begin
        req_ready  = gnt_onehot;
        req_err    = err_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch, response capture, timeout counter and fairness pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg    <= '0;
      gnt_id_reg    <= '0;
      to_cnt_reg    <= '0;
      err_reg       <= 1'b0;
      rdata_reg     <= '0;
      mem_write_reg <= 1'b0;
      mem_addr_reg  <= '0;
      mem_size_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_wmask_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_valid) begin
            gnt_id_reg    <= sel_id;
            mem_write_reg <= ch_write[sel_id];
            mem_addr_reg  <= ch_addr[sel_id];
            mem_size_reg  <= ch_size[sel_id];
            mem_wdata_reg <= ch_wdata[sel_id];
            mem_wmask_reg <= ch_wmask[sel_id];
            to_cnt_reg    <= '0;
          end
        end
        BUSY: begin
          to_cnt_reg <= to_cnt_reg + CW'(1);
          // A real answer beats a simultaneous timeout.
          if (mem_ready) begin
            rdata_reg <= mem_rdata;
            err_reg   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_reg <= '0;
            err_reg   <= 1'b1;
          end
        end
        RESP: begin
          rr_ptr_reg <= rr_after;
        end
        default: ;
      endcase
    end
  end

  assign req_rdata = rdata_reg;
  assign mem_write = mem_write_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_size  = mem_size_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_wmask = mem_wmask_reg;
  assign gnt_id    = gnt_id_reg;

endmodule

// File: tb/tb_ysyx_22040632_memreq_arb.sv
module tb_ysyx_22040632_memreq_arb;

  localparam int NCH = 4;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int MW  = 8;
  localparam int TO  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    req_valid;
  logic [NCH-1:0]    req_write;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH*3-1:0]  req_size;
  logic [NCH*DW-1:0] req_wdata;
  logic [NCH*MW-1:0] req_wmask;
  logic [NCH-1:0]    req_ready;
  logic [DW-1:0]     req_rdata;
  logic              req_err;
  logic              mem_valid;
  logic              mem_write;
  logic [AW-1:0]     mem_addr;
  logic [2:0]        mem_size;
  logic [DW-1:0]     mem_wdata;
  logic [MW-1:0]     mem_wmask;
  logic              mem_ready;
  logic [DW-1:0]     mem_rdata;
  logic [1:0]        gnt_id;

  ysyx_22040632_memreq_arb #(.NCH(NCH), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_size(req_size), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .req_ready(req_ready), .req_rdata(req_rdata), .req_err(req_err),
    .mem_valid(mem_valid), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_size(mem_size), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Requester-side state owned by the bench.
  logic [NCH-1:0] c_valid;
  logic           c_write [NCH];
  logic [AW-1:0]  c_addr  [NCH];
  logic [2:0]     c_size  [NCH];
  logic [DW-1:0]  c_wdata [NCH];
  logic [MW-1:0]  c_wmask [NCH];
  int             rr_m;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NCH; i++) begin
      req_valid[i]         = c_valid[i];
      req_write[i]         = c_write[i];
      req_addr[i*AW +: AW] = c_addr[i];
      req_size[i*3 +: 3]   = c_size[i];
      req_wdata[i*DW +: DW] = c_wdata[i];
      req_wmask[i*MW +: MW] = c_wmask[i];
    end
  endtask

  task automatic rand_fields(input int ch);
    c_write[ch] = 1'($urandom_range(0, 1));
    c_addr[ch]  = $urandom;
    c_size[ch]  = 3'($urandom_range(0, 3));
    c_wdata[ch] = {$urandom, $urandom};
    c_wmask[ch] = 8'($urandom);
  endtask

  // Reference rule: first valid channel scanning upward from rr, wrapping.
  function automatic int pick(input logic [NCH-1:0] v, input int rr);
    for (int k = 0; k < NCH; k++) begin
      if (v[(rr + k) % NCH]) return (rr + k) % NCH;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    c_valid = '0;
    for (int i = 0; i < NCH; i++) rand_fields(i);
    drive_reqs();
    mem_ready = 1'b0;
    mem_rdata = '0;
    tick();
    tick();
    rst_n = 1'b1;
    rr_m = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    rst_n = 1'b0;
    c_valid = 4'b1111;
    drive_reqs();
    tick();
    checks++;
    if ({mem_valid, req_ready, req_err, req_rdata, mem_write, mem_addr, mem_size,
         mem_wdata, mem_wmask, gnt_id} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: mem_valid=%b req_ready=%b req_err=%b rdata=%h addr=%h gnt=%0d, required all zero",
               mem_valid, req_ready, req_err, req_rdata, mem_addr, gnt_id);
    end
    c_valid = '0;
    drive_reqs();
    rst_n = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_reset_mid_busy();
    apply_reset();
    // Complete one transaction on ch0 so the pointer moves to 1.
    c_valid = 4'b0001; drive_reqs();
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    c_valid = '0; drive_reqs();
    tick();
    // Start ch1, then reset while BUSY.
    c_valid = 4'b0010; drive_reqs();
    tick();
    checks++;
    if (mem_valid !== 1'b1 || gnt_id !== 2'd1) begin
      errors++;
      $display("FAIL mid_busy_start: mem_valid=%b gnt=%0d, required 1 and 1", mem_valid, gnt_id);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_valid !== 1'b0 || gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: mem_valid=%b gnt=%0d, required 0 and 0", mem_valid, gnt_id);
    end
    c_valid = '0; drive_reqs();
    tick();
    rst_n = 1'b1;
    rr_m = 0;
    for (int c = 0; c < 6; c++) begin
      mem_ready = 1'(c % 2);
      tick();
      checks++;
      if (req_ready !== '0 || mem_valid !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_quiet: cycle %0d req_ready=%b mem_valid=%b, required 0 and 0",
                 c, req_ready, mem_valid);
      end
    end
    mem_ready = 1'b0;
    c_valid = 4'b1111; drive_reqs();
    tick();
    checks++;
    if (gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL rr_after_reset: gnt=%0d, required 0", gnt_id);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rr_after_reset_ready: req_ready=%b, required 0001", req_ready);
    end
    c_valid = '0; drive_reqs();
    tick();
    $display("test_reset_mid_busy done");
  endtask

  task automatic test_single_read();
    logic [DW-1:0] rd;
    rd = 64'h1122334455667788;
    apply_reset();
    c_valid = 4'b0010;
    c_write[1] = 1'b0;
    c_addr[1] = 32'h8000_0010;
    c_size[1] = 3'd3;
    drive_reqs();
    tick(); // cycle 1
    checks++;
    if (mem_valid !== 1'b1 || gnt_id !== 2'd1 || mem_addr !== 32'h8000_0010 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL single_read_issue: mem_valid=%b gnt=%0d addr=%h write=%b, required 1 1 80000010 0",
               mem_valid, gnt_id, mem_addr, mem_write);
    end
    tick(); // cycle 2
    tick(); // cycle 3
    checks++;
    if (req_ready !== '0) begin
      errors++;
      $display("FAIL single_read_early: req_ready=%b, required 0000", req_ready);
    end
    mem_ready = 1'b1;
    mem_rdata = rd;
    tick(); // cycle 4
    mem_ready = 1'b0;
    mem_rdata = '0;
    checks++;
    if (req_ready !== 4'b0010 || req_rdata !== rd || req_err !== 1'b0 || mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_read_resp: req_ready=%b rdata=%h err=%b mem_valid=%b, required 0010 %h 0 0",
               req_ready, req_rdata, req_err, mem_valid, rd);
    end
    c_valid = '0; drive_reqs();
    tick(); // cycle 5
    checks++;
    if (req_ready !== '0 || req_rdata !== rd) begin
      errors++;
      $display("FAIL single_read_hold: req_ready=%b rdata=%h, required 0000 %h", req_ready, req_rdata, rd);
    end
    $display("test_single_read done");
  endtask

  task automatic test_round_robin();
    apply_reset();
    c_valid = 4'b1111;
    drive_reqs();
    mem_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick(); // BUSY
      checks++;
      if (gnt_id !== 2'(t % NCH) || mem_addr !== c_addr[t % NCH]) begin
        errors++;
        $display("FAIL rr_grant: txn %0d gnt=%0d addr=%h, required %0d %h",
                 t, gnt_id, mem_addr, t % NCH, c_addr[t % NCH]);
      end
      tick(); // RESP
      checks++;
      if (req_ready !== (4'b0001 << (t % NCH))) begin
        errors++;
        $display("FAIL rr_ready: txn %0d req_ready=%b, required %b",
                 t, req_ready, 4'b0001 << (t % NCH));
      end
      tick(); // IDLE
    end
    mem_ready = 1'b0;
    c_valid = '0; drive_reqs();
    tick();
    $display("test_round_robin done");
  endtask

  task automatic test_write();
    apply_reset();
    c_valid = 4'b0001;
    c_write[0] = 1'b1;
    c_addr[0] = 32'h8000_0100;
    c_size[0] = 3'd2;
    c_wdata[0] = 64'hDEADBEEF_CAFEF00D;
    c_wmask[0] = 8'h0F;
    drive_reqs();
    for (int c = 1; c <= 5; c++) begin
      tick();
      checks++;
      if (mem_valid !== 1'b1 || mem_write !== 1'b1 || mem_addr !== 32'h8000_0100 ||
          mem_size !== 3'd2 || mem_wdata !== 64'hDEADBEEF_CAFEF00D || mem_wmask !== 8'h0F ||
          req_ready !== '0) begin
        errors++;
        $display("FAIL write_hold: cycle %0d valid=%b wr=%b addr=%h size=%0d wdata=%h wmask=%h rdy=%b, required 1 1 80000100 2 deadbeefcafef00d 0f 0000",
                 c, mem_valid, mem_write, mem_addr, mem_size, mem_wdata, mem_wmask, req_ready);
      end
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    checks++;
    if (req_ready !== 4'b0001 || req_err !== 1'b0) begin
      errors++;
      $display("FAIL write_resp: req_ready=%b err=%b, required 0001 0", req_ready, req_err);
    end
    c_valid = '0; drive_reqs();
    tick();
    $display("test_write done");
  endtask

  task automatic test_timeout();
    logic [DW-1:0] rd;
    rd = 64'hA5A5_5A5A_0123_4567;
    apply_reset();
    // mem_ready exactly on the limit cycle: the answer wins.
    c_valid = 4'b0100; drive_reqs();
    for (int c = 1; c <= TO; c++) begin
      tick();
      if (c == TO) begin
        mem_ready = 1'b1;
        mem_rdata = rd;
      end
    end
    tick(); // cycle 9
    mem_ready = 1'b0;
    checks++;
    if (req_ready !== 4'b0100 || req_err !== 1'b0 || req_rdata !== rd) begin
      errors++;
      $display("FAIL timeout_race: req_ready=%b err=%b rdata=%h, required 0100 0 %h",
               req_ready, req_err, req_rdata, rd);
    end
    c_valid = '0; drive_reqs();
    tick();
    // No answer at all: abort with error.
    c_valid = 4'b0010; drive_reqs();
    for (int c = 1; c <= TO; c++) begin
      tick();
      checks++;
      if (req_ready !== '0 || mem_valid !== 1'b1) begin
        errors++;
        $display("FAIL timeout_wait: cycle %0d req_ready=%b mem_valid=%b, required 0000 1",
                 c, req_ready, mem_valid);
      end
    end
    tick(); // cycle 9
    checks++;
    if (req_ready !== 4'b0010 || req_err !== 1'b1 || req_rdata !== '0) begin
      errors++;
      $display("FAIL timeout_abort: req_ready=%b err=%b rdata=%h, required 0010 1 0",
               req_ready, req_err, req_rdata);
    end
    c_valid = '0; drive_reqs();
    tick();
    checks++;
    if (req_ready !== '0 || req_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_after: req_ready=%b err=%b, required 0000 0", req_ready, req_err);
    end
    $display("test_timeout done");
  endtask

  task automatic test_stability();
    apply_reset();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (req_ready !== '0 || mem_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_ready_ignored: cycle %0d req_ready=%b mem_valid=%b, required 0000 0",
                 c, req_ready, mem_valid);
      end
      tick();
    end
    c_valid = 4'b1000;
    c_write[3] = 1'b0;
    c_addr[3] = 32'h1234_5678;
    c_size[3] = 3'd1;
    drive_reqs();
    tick();
    c_addr[3] = 32'h0BAD_0BAD;
    c_write[3] = 1'b1;
    c_size[3] = 3'd3;
    drive_reqs();
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (mem_addr !== 32'h1234_5678 || mem_write !== 1'b0 || mem_size !== 3'd1) begin
        errors++;
        $display("FAIL busy_latched: addr=%h write=%b size=%0d, required 12345678 0 1",
                 mem_addr, mem_write, mem_size);
      end
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL stability_resp: req_ready=%b, required 1000", req_ready);
    end
    c_valid = '0; drive_reqs();
    tick();
    $display("test_stability done");
  endtask

  task automatic test_random();
    int g, d, idx;
    bit done;
    logic [DW-1:0] exp_rd;
    logic exp_err;
    logic [1+3+AW+DW+MW-1:0] exp_f;
    apply_reset();
    for (int t = 0; t < 40; t++) begin
      // IDLE cycle: new requests may appear on idle channels.
      for (int i = 0; i < NCH; i++) begin
        if (!c_valid[i] && $urandom_range(0, 2) == 0) begin
          rand_fields(i);
          c_valid[i] = 1'b1;
        end
      end
      if (c_valid == '0) begin
        g = $urandom_range(0, NCH - 1);
        rand_fields(g);
        c_valid[g] = 1'b1;
      end
      drive_reqs();
      g = pick(c_valid, rr_m);
      exp_f = {c_write[g], c_size[g], c_addr[g], c_wdata[g], c_wmask[g]};
      d = $urandom_range(0, 9);
      done = 1'b0;
      idx = 0;
      exp_rd = '0;
      exp_err = 1'b0;
      while (!done && idx < TO) begin
        tick(); // BUSY cycle idx
        checks++;
        if (mem_valid !== 1'b1 || gnt_id !== 2'(g) ||
            {mem_write, mem_size, mem_addr, mem_wdata, mem_wmask} !== exp_f) begin
          errors++;
          $display("FAIL rand_busy: txn %0d cyc %0d valid=%b gnt=%0d addr=%h, required 1 %0d %h",
                   t, idx, mem_valid, gnt_id, mem_addr, g, exp_f[AW+DW+MW-1 -: AW]);
        end
        mem_rdata = {$urandom, $urandom};
        if (idx == d) begin
          mem_ready = 1'b1;
          exp_rd = mem_rdata;
          exp_err = 1'b0;
          done = 1'b1;
        end else begin
          mem_ready = 1'b0;
          if (idx == TO - 1) begin
            exp_rd = '0;
            exp_err = 1'b1;
            done = 1'b1;
          end
        end
        idx++;
      end
      tick(); // RESP
      mem_ready = 1'($urandom_range(0, 1));
      checks++;
      if (req_ready !== (4'b0001 << g) || req_rdata !== exp_rd || req_err !== exp_err) begin
        errors++;
        $display("FAIL rand_resp: txn %0d req_ready=%b rdata=%h err=%b, required %b %h %b",
                 t, req_ready, req_rdata, req_err, 4'b0001 << g, exp_rd, exp_err);
      end
      $display("txn %0d ch=%0d delay=%0d err=%b", t, g, d, exp_err);
      rr_m = (g + 1) % NCH;
      c_valid[g] = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        rand_fields(g);
        c_valid[g] = 1'b1;
      end
      drive_reqs();
      tick(); // IDLE
      mem_ready = 1'b0;
      checks++;
      if (mem_valid !== 1'b0 || req_ready !== '0) begin
        errors++;
        $display("FAIL rand_idle: txn %0d mem_valid=%b req_ready=%b, required 0 0000",
                 t, mem_valid, req_ready);
      end
    end
    c_valid = '0; drive_reqs();
    tick();
    $display("test_random done");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    c_valid = '0;
    for (int i = 0; i < NCH; i++) rand_fields(i);
    drive_reqs();
    mem_ready = 1'b0;
    mem_rdata = '0;
    test_reset();
    test_reset_mid_busy();
    test_single_read();
    test_round_robin();
    test_write();
    test_timeout();
    test_stability();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
